// File: rtl/fifo_write_arbiter.sv
// Packet-level round-robin arbiter for the async FIFO write port.
// Optional per-requester beat and stall statistics: define FIFO_ARB_STATS_EN.
module fifo_write_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 8,
   parameter int IDX_WIDTH  = $clog2(NUM_REQ)
) (
   input  logic                          write_clk,
   input  logic                          write_reset,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ-1:0]            req_last,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   output logic [NUM_REQ-1:0]            req_ready,
   input  logic                          write_full,
   output logic                          write_incr,
   output logic [DATA_WIDTH-1:0]         write_data,
   output logic                          grant_valid,
   output logic [IDX_WIDTH-1:0]          grant_idx
`ifdef FIFO_ARB_STATS_EN
   ,
   output logic [NUM_REQ*16-1:0]         beat_count,
   output logic [15:0]                   stall_count
`endif
);

   typedef enum logic [0:0] {
      S_IDLE   = 1'b0,
      S_LOCKED = 1'b1
   } state_t;

   state_t                 state_q, state_d;
   logic [IDX_WIDTH-1:0]   grant_q, grant_d;
   logic [IDX_WIDTH-1:0]   rr_q, rr_d;
   logic                   transfer_s;
   logic                   pkt_end_s;
   logic [IDX_WIDTH-1:0]   ptr_next_s;
   logic [NUM_REQ-1:0]     others_s;
   logic [IDX_WIDTH:0]     pick_idle_s;
   logic [IDX_WIDTH:0]     pick_end_s;

   // Returns {found, index} of the first set bit of vec scanning upward from ptr with wrap.
   function automatic logic [IDX_WIDTH:0] rr_pick(input logic [NUM_REQ-1:0] vec,
                                                  input logic [IDX_WIDTH-1:0] ptr);
      logic                 found;
      logic [IDX_WIDTH-1:0] idx;
      int                   j;
      found = 1'b0;
      idx   = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         j = int'(ptr) + k;
         if (j >= NUM_REQ) begin
            j = j - NUM_REQ;
         end else begin
            j = j;
         end
         if (!found && vec[IDX_WIDTH'(j)]) begin
            found = 1'b1;
            idx   = IDX_WIDTH'(j);
         end else begin
            found = found;
         end
      end
      return {found, idx};
   endfunction

   assign transfer_s  = (state_q == S_LOCKED) && req_valid[grant_q] && !write_full;
   assign pkt_end_s   = transfer_s && req_last[grant_q];
   assign ptr_next_s  = (grant_q == IDX_WIDTH'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
   assign pick_idle_s = rr_pick(req_valid, rr_q);
   assign pick_end_s  = rr_pick(others_s, ptr_next_s);
   assign grant_idx   = grant_q;

   // The finishing owner is masked out of the back-to-back re-arbitration.
   always_comb begin
      others_s           = req_valid;
      others_s[grant_q]  = 1'b0;
   end

   always_ff @(posedge write_clk) begin
      if (write_reset) begin
         state_q <= S_IDLE;
         grant_q <= '0;
         rr_q    <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         rr_q    <= rr_d;
      end
   end

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      rr_d    = rr_q;
      case (state_q)
         S_IDLE: begin
            if (pick_idle_s[IDX_WIDTH]) begin
               state_d = S_LOCKED;
               grant_d = pick_idle_s[IDX_WIDTH-1:0];
            end else begin
               state_d = S_IDLE;
            end
         end
         S_LOCKED: begin
            if (pkt_end_s) begin
               rr_d = ptr_next_s;
               if (pick_end_s[IDX_WIDTH]) begin
                  grant_d = pick_end_s[IDX_WIDTH-1:0];
               end else begin
                  state_d = S_IDLE;
               end
            end else begin
               state_d = S_LOCKED;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_comb begin
      grant_valid = 1'b0;
      req_ready   = '0;
      write_incr  = 1'b0;
      write_data  = '0;
      case (state_q)
         S_LOCKED: begin
            grant_valid        = 1'b1;
            req_ready[grant_q] = !write_full;
            write_incr         = transfer_s;
            if (transfer_s) begin
               write_data = req_data[grant_q*DATA_WIDTH +: DATA_WIDTH];
            end else begin
               write_data = '0;
            end
         end
         default: begin
            grant_valid = 1'b0;
         end
      endcase
   end

`ifdef FIFO_ARB_STATS_EN
   logic [15:0] beat_q [NUM_REQ];
   logic [15:0] stall_q;

   // Saturating counters; they hold at all-ones rather than wrapping.
   always_ff @(posedge write_clk) begin
      if (write_reset) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            beat_q[i] <= 16'h0000;
         end
         stall_q <= 16'h0000;
      end else begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (transfer_s && (grant_q == IDX_WIDTH'(i)) && (beat_q[i] != 16'hFFFF)) begin
               beat_q[i] <= beat_q[i] + 16'h0001;
            end else begin
               beat_q[i] <= beat_q[i];
            end
         end
         if ((state_q == S_LOCKED) && req_valid[grant_q] && write_full && (stall_q != 16'hFFFF)) begin
            stall_q <= stall_q + 16'h0001;
         end else begin
            stall_q <= stall_q;
         end
      end
   end

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_beat_out
      assign beat_count[g*16 +: 16] = beat_q[g];
   end
   assign stall_count = stall_q;
`endif

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Self-checking bench for fifo_write_arbiter (NUM_REQ=4, DATA_WIDTH=8).
module tb_fifo_write_arbiter;

   logic        write_clk;
   logic        write_reset;
   logic [3:0]  req_valid;
   logic [3:0]  req_last;
   logic [31:0] req_data;
   logic [3:0]  req_ready;
   logic        write_full;
   logic        write_incr;
   logic [7:0]  write_data;
   logic        grant_valid;
   logic [1:0]  grant_idx;
`ifdef FIFO_ARB_STATS_EN
   logic [63:0] beat_count;
   logic [15:0] stall_count;
`endif

   int checks = 0;
   int errors = 0;

   fifo_write_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8)) dut (
      .write_clk   (write_clk),
      .write_reset (write_reset),
      .req_valid   (req_valid),
      .req_last    (req_last),
      .req_data    (req_data),
      .req_ready   (req_ready),
      .write_full  (write_full),
      .write_incr  (write_incr),
      .write_data  (write_data),
      .grant_valid (grant_valid),
      .grant_idx   (grant_idx)
`ifdef FIFO_ARB_STATS_EN
      ,
      .beat_count  (beat_count),
      .stall_count (stall_count)
`endif
   );

   initial write_clk = 1'b0;
   always #5 write_clk = ~write_clk;

   typedef struct {
      logic [3:0]  v;
      logic [3:0]  l;
      logic [31:0] d;
      logic        f;
      logic        gv;
      logic [1:0]  idx;
      logic [3:0]  rdy;
      logic        inc;
      logic [7:0]  dat;
   } vec_t;

   vec_t tbl [7];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Observed outputs bundled; grant_idx only matters while a grant is held.
   function automatic logic [15:0] obs();
      return {grant_valid, (grant_valid ? grant_idx : 2'b00), req_ready, write_incr, write_data};
   endfunction

   task automatic drive(input logic rst, input logic [3:0] v, input logic [3:0] l,
                        input logic [31:0] d, input logic f);
      @(negedge write_clk);
      write_reset = rst;
      req_valid   = v;
      req_last    = l;
      req_data    = d;
      write_full  = f;
      #1;
   endtask

   task automatic do_reset();
      @(negedge write_clk);
      write_reset = 1'b1;
      req_valid   = 4'b0000;
      req_last    = 4'b0000;
      req_data    = 32'h0;
      write_full  = 1'b0;
      @(negedge write_clk);
      write_reset = 1'b0;
      #1;
   endtask

   initial begin
      int incr_cnt;
      int a5_cnt;
      int owner;
      int ptr;
      int o;
      logic        r;
      logic        f;
      logic        tr;
      logic        inc;
      logic [3:0]  v;
      logic [3:0]  l;
      logic [3:0]  rdy;
      logic [31:0] d;
      logic [7:0]  dat;

      write_reset = 1'b1;
      req_valid   = 4'b0000;
      req_last    = 4'b0000;
      req_data    = 32'h0;
      write_full  = 1'b0;

      // Two requesters, two beats each: grant 0, zero-bubble switch to 2, then idle.
      tbl[0] = '{4'b0101, 4'b0000, 32'h0020_0010, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0, 8'h00};
      tbl[1] = '{4'b0101, 4'b0000, 32'h0020_0010, 1'b0, 1'b1, 2'd0, 4'b0001, 1'b1, 8'h10};
      tbl[2] = '{4'b0101, 4'b0001, 32'h0020_0011, 1'b0, 1'b1, 2'd0, 4'b0001, 1'b1, 8'h11};
      tbl[3] = '{4'b0100, 4'b0000, 32'h0020_0000, 1'b0, 1'b1, 2'd2, 4'b0100, 1'b1, 8'h20};
      tbl[4] = '{4'b0100, 4'b0100, 32'h0021_0000, 1'b0, 1'b1, 2'd2, 4'b0100, 1'b1, 8'h21};
      tbl[5] = '{4'b0000, 4'b0000, 32'h0000_0000, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0, 8'h00};
      tbl[6] = '{4'b0000, 4'b0000, 32'h0000_0000, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0, 8'h00};

      do_reset();
      chk("reset_state", {grant_valid, grant_idx, req_ready, write_incr, write_data}, 64'h0);

      incr_cnt = 0;
      for (int i = 0; i < 7; i++) begin
         drive(1'b0, tbl[i].v, tbl[i].l, tbl[i].d, tbl[i].f);
         chk($sformatf("table_row%0d", i), obs(),
             {tbl[i].gv, tbl[i].idx, tbl[i].rdy, tbl[i].inc, tbl[i].dat});
         if (write_incr) incr_cnt++;
      end
      chk("table_incr_total", incr_cnt, 4);

      // Round robin with 1-beat packets from all requesters.
      do_reset();
      drive(1'b0, 4'b1111, 4'b1111, 32'h4433_2211, 1'b0);
      chk("rr_first_idle", grant_valid, 1'b0);
      for (int i = 0; i < 6; i++) begin
         drive(1'b0, 4'b1111, 4'b1111, 32'h4433_2211, 1'b0);
         chk($sformatf("rr_grant%0d", i), {grant_valid, grant_idx, write_incr}, {1'b1, 2'(i % 4), 1'b1});
      end

      // Owner 1 held off by write_full for three cycles; A5 written exactly once.
      do_reset();
      a5_cnt = 0;
      drive(1'b0, 4'b0010, 4'b0000, 32'h0000_0100, 1'b0);
      drive(1'b0, 4'b0010, 4'b0000, 32'h0000_0100, 1'b0);
      chk("full_beat1", {write_incr, write_data}, {1'b1, 8'h01});
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 4'b0010, 4'b0000, 32'h0000_A500, 1'b1);
         chk($sformatf("full_hold%0d", i), {grant_valid, grant_idx, req_ready, write_incr},
             {1'b1, 2'd1, 4'b0000, 1'b0});
         if (write_incr && write_data == 8'hA5) a5_cnt++;
      end
      drive(1'b0, 4'b0010, 4'b0000, 32'h0000_A500, 1'b0);
      chk("full_release", {req_ready, write_incr, write_data}, {4'b0010, 1'b1, 8'hA5});
      if (write_incr && write_data == 8'hA5) a5_cnt++;
      drive(1'b0, 4'b0010, 4'b0010, 32'h0000_0200, 1'b0);
      if (write_incr && write_data == 8'hA5) a5_cnt++;
      chk("full_last", {write_incr, write_data}, {1'b1, 8'h02});
      chk("full_a5_once", a5_cnt, 1);
      drive(1'b0, 4'b0000, 4'b0000, 32'h0, 1'b0);
      chk("full_idle", grant_valid, 1'b0);

      // Owner 2 gaps for two cycles while requester 3 waits.
      do_reset();
      drive(1'b0, 4'b0100, 4'b0000, 32'h0022_0000, 1'b0);
      drive(1'b0, 4'b1100, 4'b0000, 32'h3322_0000, 1'b0);
      chk("gap_beat1", obs(), {1'b1, 2'd2, 4'b0100, 1'b1, 8'h22});
      for (int i = 0; i < 2; i++) begin
         drive(1'b0, 4'b1000, 4'b0000, 32'h3300_0000, 1'b0);
         chk($sformatf("gap_hold%0d", i), {grant_idx, write_incr, req_ready}, {2'd2, 1'b0, 4'b0100});
      end
      drive(1'b0, 4'b1100, 4'b0100, 32'h3323_0000, 1'b0);
      chk("gap_last", obs(), {1'b1, 2'd2, 4'b0100, 1'b1, 8'h23});
      drive(1'b0, 4'b1000, 4'b1000, 32'h3300_0000, 1'b0);
      chk("gap_next_owner", obs(), {1'b1, 2'd3, 4'b1000, 1'b1, 8'h33});

      // Reset mid-packet: pointer (at 2) must return to 0.
      do_reset();
      drive(1'b0, 4'b0010, 4'b0010, 32'h0000_0100, 1'b0);
      drive(1'b0, 4'b0010, 4'b0010, 32'h0000_0100, 1'b0);
      chk("rst_pre_pkt", {grant_idx, write_incr}, {2'd1, 1'b1});
      drive(1'b0, 4'b0100, 4'b0000, 32'h0044_0000, 1'b0);
      drive(1'b0, 4'b0100, 4'b0000, 32'h0044_0000, 1'b0);
      drive(1'b0, 4'b0100, 4'b0000, 32'h0045_0000, 1'b0);
      chk("rst_beat2", {grant_idx, write_incr, write_data}, {2'd2, 1'b1, 8'h45});
      drive(1'b1, 4'b1101, 4'b0000, 32'h0046_0000, 1'b0);
      drive(1'b0, 4'b1001, 4'b0000, 32'h0, 1'b0);
      chk("rst_cleared", obs(), 16'h0000);
      drive(1'b0, 4'b1001, 4'b0000, 32'h0, 1'b0);
      chk("rst_grant0", {grant_valid, grant_idx}, {1'b1, 2'd0});

`ifdef FIFO_ARB_STATS_EN
      do_reset();
      drive(1'b0, 4'b1000, 4'b0000, 32'h0, 1'b0);
      drive(1'b0, 4'b1000, 4'b0000, 32'h0100_0000, 1'b0);
      drive(1'b0, 4'b1000, 4'b0000, 32'h0200_0000, 1'b0);
      drive(1'b0, 4'b1000, 4'b0000, 32'h0300_0000, 1'b1);
      drive(1'b0, 4'b1000, 4'b0000, 32'h0300_0000, 1'b1);
      drive(1'b0, 4'b1000, 4'b0000, 32'h0300_0000, 1'b0);
      drive(1'b0, 4'b1000, 4'b0000, 32'h0400_0000, 1'b0);
      drive(1'b0, 4'b1000, 4'b1000, 32'h0500_0000, 1'b0);
      drive(1'b0, 4'b0000, 4'b0000, 32'h0, 1'b0);
      chk("stats_beats", beat_count, {16'd5, 16'd0, 16'd0, 16'd0});
      chk("stats_stall", stall_count, 16'd2);
`endif

      // Randomised traffic against a packet-level reference model.
      do_reset();
      owner = -1;
      ptr   = 0;
      for (int c = 0; c < 800; c++) begin
         r = ($urandom_range(0, 59) == 0);
         v = 4'($urandom);
         l = 4'($urandom) & 4'($urandom);
         d = $urandom;
         f = ($urandom_range(0, 3) == 0);
         drive(r, v, l, d, f);
         rdy = 4'b0000;
         inc = 1'b0;
         dat = 8'h00;
         tr  = 1'b0;
         if (owner >= 0) begin
            rdy[owner] = !f;
            tr  = v[owner] && !f;
            inc = tr;
            if (tr) dat = d[owner*8 +: 8];
         end
         chk("random", obs(), {(owner >= 0), (owner >= 0 ? 2'(owner) : 2'b00), rdy, inc, dat});
         if (r) begin
            owner = -1;
            ptr   = 0;
         end else if (owner < 0) begin
            for (int k = 0; k < 4; k++) begin
               if (owner < 0 && v[(ptr + k) % 4]) owner = (ptr + k) % 4;
            end
         end else if (tr && l[owner]) begin
            o     = owner;
            ptr   = (o + 1) % 4;
            owner = -1;
            for (int k = 0; k < 3; k++) begin
               if (owner < 0 && v[(ptr + k) % 4]) owner = (ptr + k) % 4;
            end
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fifo_write_arbiter.md
Name: fifo_write_arbiter

Overview:
Packet-level round-robin arbiter that shares the single write port of the async FIFO write side among NUM_REQ requesters in the write clock domain. Once a requester is granted, it owns the port until it transfers a beat marked last. The arbiter drives the FIFO's write_incr and write data, and honours write_full so that no beat is lost or duplicated.

Parameters:
NUM_REQ, 4, number of requesters (2..16)
DATA_WIDTH, 8, width of one data beat
IDX_WIDTH, $clog2(NUM_REQ), width of the grant index (derived; do not override)

Ports:
write_clk  input  1  write-domain clock; all logic on its rising edge
write_reset  input  1  synchronous, active-high reset
req_valid  input  NUM_REQ  per-requester beat valid
req_last  input  NUM_REQ  per-requester last-beat-of-packet flag, qualified by req_valid
req_data  input  NUM_REQ*DATA_WIDTH  packed beats; requester i occupies [i*DATA_WIDTH +: DATA_WIDTH]
req_ready  output  NUM_REQ  per-requester accept; a beat transfers when req_valid[i] & req_ready[i]
write_full  input  1  full flag from the FIFO write side
write_incr  output  1  write strobe to the FIFO; high exactly on a transfer cycle
write_data  output  DATA_WIDTH  data beat presented to the FIFO memory
grant_valid  output  1  a requester currently owns the port
grant_idx  output  IDX_WIDTH  index of the owning requester

Behaviour:
- Interface: one clock (write_clk); reset (write_reset) is synchronous and active-high.
- Reset values: state=IDLE, grant_valid=0, grant_idx=0, rr pointer=0, req_ready=0, write_incr=0, write_data=0 (masked when no transfer).
- State machine:
  - IDLE: grant_valid=0.
    - If any req_valid is high at the edge, select the first set bit scanning from rr pointer upward with wrap.
    - Register the winner into grant_idx and go to LOCKED.
    - The first beat can transfer on the following cycle (1-cycle arbitration latency).
  - LOCKED: grant_valid=1.
    - req_ready[grant_idx] = ~write_full; all other req_ready bits are 0.
    - transfer = req_valid[grant_idx] & ~write_full.
    - write_incr = transfer.
    - write_data = req_data slice of grant_idx when transfer is high, else 0.
- Packet end: on a transfer with req_last[grant_idx]=1, rr pointer becomes grant_idx+1 (mod NUM_REQ).
  - In that same edge, re-arbitrate from the new pointer using the current req_valid, excluding grant_idx.
  - Winner found: stay LOCKED with the new grant_idx (zero bubble).
  - No winner: go to IDLE.
  - The finishing requester is reconsidered only from IDLE or later rounds.
- Lock hold:
  - Owner deasserts req_valid mid-packet: stay LOCKED, no write_incr, no re-arbitration.
  - Non-owner requests are ignored until the owner's last beat.
- Full: while write_full=1, req_ready and write_incr are 0. The beat stays pending and transfers on the first cycle write_full=0. Never write while full.
- Single-beat packet (req_last on the first beat) is legal.
- NUM_REQ not a power of two: the pointer wraps at NUM_REQ, and grant_idx never exceeds NUM_REQ-1.
- req_last without req_valid has no effect.
- write_reset asserted mid-packet: the packet is abandoned, and the arbiter returns to the reset values on the next edge.

Optional Feature:
FIFO_ARB_STATS_EN
- Defined:
  - Adds output beat_count, NUM_REQ*16 bits, packed like req_data: one saturating 16-bit counter per requester, incremented on each of its transfers. It holds at 16'hFFFF.
  - Adds output stall_count, 16 bits, saturating: counts cycles with grant_valid & req_valid[grant_idx] & write_full.
  - All counters clear on write_reset.
- Undefined: these ports and their logic do not exist; all other behaviour is identical.

Test Plan:
- Reset, then req_valid=4'b0101, each sending 2 beats (last on beat 2) with write_full=0.
  - Grant 0 one cycle after the request; beats 0,0 transfer.
  - grant_idx switches to 2 with no bubble; beats 2,2 transfer.
  - Then IDLE; write_incr high for exactly 4 cycles.
- All 4 requesters continuously valid with 1-beat packets -> grant order 0,1,2,3,0,1.
  - write_incr high every cycle after the first grant.
- Owner 1 mid-packet with write_full asserted for 3 cycles -> req_ready[1]=0 and write_incr=0 for those 3 cycles.
  - The same write_data beat (e.g. 8'hA5) is written once after full drops.
- Owner 2 drops req_valid for 2 cycles mid-packet while requester 3 is valid -> grant_idx stays 2 and no write_incr during the gap.
  - Requester 3 is granted only after 2's last beat.
- write_reset asserted during a 4-beat packet after beat 2 -> next cycle grant_valid=0, req_ready=0.
  - After release with req_valid=4'b0001, requester 0 is granted (pointer back to 0).
- With FIFO_ARB_STATS_EN: requester 3 sends 5 beats with 2 full cycles -> beat_count[3]=5, stall_count=2, all other beat counts 0.
